div_unit_iter: RTL and testbench

//  Parametrised iterative integer divider for the EX stage: DIV/DIVU/REM/REMU.

---
 rtl/div_unit_iter_pkg.sv | 36 +++
 rtl/div_unit_iter_step.sv | 35 +++
 rtl/div_unit_iter.sv | 170 +++++++++++++++++
 tb/tb_div_unit_iter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_iter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : div_pkg
// Purpose  : Shared types and ALU-op decode for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    typedef struct packed {
        logic is_signed;
        logic want_rem;
    } div_func_t;

    typedef enum logic [1:0] {
        ALU_DIV  = 2'd0,
        ALU_DIVU = 2'd1,
        ALU_REM  = 2'd2,
        ALU_REMU = 2'd3
    } div_op_t;

    function automatic div_func_t div_decode(input div_op_t op);
        div_func_t f;
        f.is_signed = (op == ALU_DIV) || (op == ALU_REM);
        f.want_rem  = (op == ALU_REM) || (op == ALU_REMU);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit_iter_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : Combinational chain of BITS_PER_CYCLE restoring divide steps.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [XLEN:0]             rem_i,
    input  logic [BITS_PER_CYCLE-1:0] dvd_bits_i,
    input  logic [XLEN-1:0]           divisor_i,
    output logic [XLEN:0]             rem_o,
    output logic [BITS_PER_CYCLE-1:0] q_bits_o
);

    logic [BITS_PER_CYCLE:0][XLEN:0] w_rem;

    assign w_rem[0] = rem_i;

    // Dividend bits enter MSB first; a clear sign bit on the trial difference means it fits.
    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
        logic [XLEN+1:0] w_shift;
        logic [XLEN+1:0] w_diff;
        assign w_shift = {w_rem[j], dvd_bits_i[BITS_PER_CYCLE-1-j]};
        assign w_diff  = w_shift - {2'b00, divisor_i};
        assign q_bits_o[BITS_PER_CYCLE-1-j] = ~w_diff[XLEN+1];
        assign w_rem[j+1] = w_diff[XLEN+1] ? w_shift[XLEN:0] : w_diff[XLEN:0];
    end

    assign rem_o = w_rem[BITS_PER_CYCLE];

endmodule
`default_nettype wire

// File: rtl/div_unit_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_iter
// Purpose  : Iterative DIV/DIVU/REM/REMU unit, BITS_PER_CYCLE quotient bits per clock.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit_iter
    import div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld_i,
    output logic            in_rdy_o,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    input  logic            is_signed_i,
    input  logic            want_rem_i,
    input  logic            flush_i,
    output logic            out_vld_o,
    input  logic            out_rdy_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int              c_iters   = XLEN / BITS_PER_CYCLE;
    localparam int              c_cnt_w   = $clog2(c_iters + 1);
    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]    dq_q, dq_d;
    logic [XLEN-1:0]    dvs_q, dvs_d;
    logic [XLEN:0]      rem_q, rem_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               want_rem_q, want_rem_d;

    div_func_t                 w_func;
    logic                      w_accept;
    logic                      w_div0;
    logic                      w_ovf;
    logic [XLEN-1:0]           w_abs_a;
    logic [XLEN-1:0]           w_abs_b;
    logic [XLEN-1:0]           w_special;
    logic [XLEN:0]             w_step_rem;
    logic [BITS_PER_CYCLE-1:0] w_q_bits;
    logic [XLEN-1:0]           w_q_fix;
    logic [XLEN-1:0]           w_r_fix;

    assign w_func.is_signed = is_signed_i;
    assign w_func.want_rem  = want_rem_i;

    assign w_accept = in_vld_i && (state_q == IDLE) && !flush_i;
    assign w_div0   = (opb_i == '0);
    assign w_ovf    = w_func.is_signed && (opa_i == c_int_min) && (opb_i == '1);
    assign w_abs_a  = (w_func.is_signed && opa_i[XLEN-1]) ? -opa_i : opa_i;
    assign w_abs_b  = (w_func.is_signed && opb_i[XLEN-1]) ? -opb_i : opb_i;

    // Divide-by-zero and INT_MIN/-1 bypass the iteration entirely.
    assign w_special = w_func.want_rem ? (w_div0 ? opa_i : '0)
                                       : (w_div0 ? '1 : c_int_min);

    // Dividend and quotient share one register: dividend bits leave the top
    // as quotient bits enter the bottom.
    div_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .rem_i      (rem_q),
        .dvd_bits_i (dq_q[XLEN-1 -: BITS_PER_CYCLE]),
        .divisor_i  (dvs_q),
        .rem_o      (w_step_rem),
        .q_bits_o   (w_q_bits)
    );

    assign w_q_fix = q_neg_q ? -dq_q : dq_q;
    assign w_r_fix = r_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dq_d       = dq_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        result_d   = result_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        want_rem_d = want_rem_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    dq_d       = w_abs_a;
                    dvs_d      = w_abs_b;
                    rem_d      = '0;
                    cnt_d      = c_cnt_w'(c_iters - 1);
                    q_neg_d    = w_func.is_signed & (opa_i[XLEN-1] ^ opb_i[XLEN-1]);
                    r_neg_d    = w_func.is_signed & opa_i[XLEN-1];
                    want_rem_d = w_func.want_rem;
                    if (w_div0 || w_ovf) begin
                        result_d = w_special;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = w_step_rem;
                dq_d  = (dq_q << BITS_PER_CYCLE) | XLEN'(w_q_bits);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            FIX: begin
                result_d = want_rem_q ? w_r_fix : w_q_fix;
                state_d  = DONE;
            end
            DONE: begin
                if (out_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A squashed op must not disturb the last delivered result.
        if (flush_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dq_q       <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            result_q   <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            want_rem_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dq_q       <= dq_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            want_rem_q <= want_rem_d;
        end
    end

    assign in_rdy_o  = (state_q == IDLE);
    assign out_vld_o = (state_q == DONE);
    assign busy_o    = (state_q != IDLE);
    assign result_o  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit_iter
// Purpose  : Directed bench for div_unit_iter at BITS_PER_CYCLE = 1, 2, 4, 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit_iter;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        in_vld    = 1'b0;
    logic        is_signed = 1'b0;
    logic        want_rem  = 1'b0;
    logic        flush     = 1'b0;
    logic        out_rdy   = 1'b0;
    logic [31:0] opa       = '0;
    logic [31:0] opb       = '0;

    wire  [3:0]  in_rdy;
    wire  [3:0]  out_vld;
    wire  [3:0]  busy;
    wire  [31:0] res [0:3];

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        div_unit_iter #(
            .XLEN           (32),
            .BITS_PER_CYCLE (1 << g)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_vld_i    (in_vld),
            .in_rdy_o    (in_rdy[g]),
            .opa_i       (opa),
            .opb_i       (opb),
            .is_signed_i (is_signed),
            .want_rem_i  (want_rem),
            .flush_i     (flush),
            .out_vld_o   (out_vld[g]),
            .out_rdy_i   (out_rdy),
            .result_o    (res[g]),
            .busy_o      (busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latency n = edges after the accept edge before out_vld is seen;
    // a special case is ready for the consumer at the very next edge (n = 0).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic rem,
                          input logic [31:0] exp, input bit special);
        int lat [4];
        bit all_seen;
        for (int g = 0; g < 4; g++) lat[g] = -1;
        opa = a; opb = b; is_signed = sgn; want_rem = rem; in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        opa = $urandom; opb = $urandom; is_signed = ~sgn; want_rem = ~rem;
        for (int n = 0; n <= 40; n++) begin
            all_seen = 1'b1;
            for (int g = 0; g < 4; g++) begin
                if (out_vld[g] === 1'b1 && lat[g] < 0) lat[g] = n;
                if (lat[g] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
            step();
        end
        for (int g = 0; g < 4; g++) begin
            check_eq($sformatf("%s_B%0d_lat", tag, 1 << g), 32'(lat[g]),
                     special ? 32'd0 : 32'((32 >> g) + 1));
            check_eq($sformatf("%s_B%0d_res", tag, 1 << g), res[g], exp);
        end
    endtask

    task automatic release_out(input string tag);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        check_eq({tag, "_in_rdy"},  32'(in_rdy),  32'hF);
        check_eq({tag, "_out_vld"}, 32'(out_vld), 32'h0);
    endtask

    initial begin
        #1 rst = 1'b1;
        step();
        check_eq("rst_in_rdy",  32'(in_rdy),  32'hF);
        check_eq("rst_out_vld", 32'(out_vld), 32'h0);
        check_eq("rst_busy",    32'(busy),    32'h0);
        check_eq("rst_result",  res[0],       32'h0);
        rst = 1'b0;
        step();

        run_op("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0);
        // In_vld while DONE must be ignored and the result must hold.
        for (int i = 0; i < 10; i++) begin
            in_vld = 1'b1; opa = 32'd50; opb = 32'd5;
            step();
            check_eq("hold_result", res[0], 32'd14);
            check_eq("hold_in_rdy", 32'(in_rdy), 32'h0);
        end
        in_vld = 1'b0;
        release_out("hold");
        run_op("remu_100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 1'b0);
        release_out("remu");

        run_op("div_m7_2",   32'hFFFF_FFF9, 32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0);
        release_out("div_m7_2");
        run_op("rem_m7_2",   32'hFFFF_FFF9, 32'd2,          1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        release_out("rem_m7_2");
        run_op("rem_7_m2",   32'd7,         32'hFFFF_FFFE,  1'b1, 1'b1, 32'd1,         1'b0);
        release_out("rem_7_m2");
        run_op("div_m100_7", 32'hFFFF_FF9C, 32'd7,          1'b1, 1'b0, 32'hFFFF_FFF2, 1'b0);
        release_out("div_m100_7");

        run_op("div_5_0",    32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        release_out("div_5_0");
        run_op("rem_5_0",    32'd5, 32'd0, 1'b1, 1'b1, 32'd5,         1'b1);
        release_out("rem_5_0");
        run_op("divu_0_0",   32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        release_out("divu_0_0");
        run_op("div_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
        release_out("div_ovf");
        run_op("rem_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0,         1'b1);
        release_out("rem_ovf");
        run_op("divu_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         1'b0);
        release_out("divu_ovf");
        run_op("divu_max_1", 32'hFFFF_FFFF, 32'd1,  1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        release_out("divu_max_1");
        run_op("remu_max16", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, 32'hF,         1'b0);
        release_out("remu_max16");

        // Flush mid-CALC: back to IDLE, no result, last result kept.
        opa = 32'd1000; opb = 32'd3; is_signed = 1'b0; want_rem = 1'b0; in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        repeat (5) step();
        check_eq("flush_pre_busy", 32'(busy[0]), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_busy",    32'(busy),    32'h0);
        check_eq("flush_out_vld", 32'(out_vld), 32'h0);
        check_eq("flush_result",  res[0],       32'hF);
        repeat (3) step();
        check_eq("flush_quiet",   32'(out_vld), 32'h0);
        in_vld = 1'b1; flush = 1'b1;
        step();
        in_vld = 1'b0; flush = 1'b0;
        check_eq("flush_vld_busy", 32'(busy), 32'h0);
        run_op("divu_9_3", 32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 1'b0);
        release_out("divu_9_3");

        // Asynchronous reset between clock edges mid-CALC.
        opa = 32'd100; opb = 32'd7; is_signed = 1'b0; want_rem = 1'b0; in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check_eq("arst_in_rdy",  32'(in_rdy),  32'hF);
        check_eq("arst_out_vld", 32'(out_vld), 32'h0);
        check_eq("arst_busy",    32'(busy),    32'h0);
        for (int g = 0; g < 4; g++)
            check_eq($sformatf("arst_B%0d_result", 1 << g), res[g], 32'h0);
        #2 rst = 1'b0;
        run_op("post_rst", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 1'b0);
        release_out("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
